pico_oversampler: RTL and testbench

PICO_OVERSAMPLER -- requirements
Module: pico_oversampler

---
 rtl/spi_pkg.sv | 13 +
 rtl/bit_synchronizer.sv | 23 ++
 rtl/pico_oversampler.sv | 128 ++++++++++++
 tb/tb_pico_oversampler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizes for the pico SPI oversampling receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } pico_state_t;

    localparam int SPI_BYTE_W            = 8;
    localparam int PICO_IDLE_TIMEOUT_DEF = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit multi-flop synchronizer; output lags input by depth cycles.
module bit_synchronizer #(
    parameter int depth = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [depth-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[depth-2:0], i_d};
        end
    end

    assign o_q = r_sync[depth-1];

endmodule

// File: rtl/pico_oversampler.sv
// SPI peripheral receiver oversampled on iclk: address byte then data bytes, idle timeout ends frame.
// Address auto-increment after each data byte is enabled by defining PICO_ADDR_AUTOINC_EN.
module pico_oversampler
    import spi_pkg::*;
#(
    parameter int IDLE_TIMEOUT = PICO_IDLE_TIMEOUT_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  iclk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  serial_in,
    output logic                  msg_flag,
    output logic [SPI_BYTE_W-1:0] write_data,
    output logic [SPI_BYTE_W-1:0] mux_control_signal,
    output logic                  frame_active,
    output logic                  frame_end
);

    localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    logic                  w_sclk_s;
    logic                  w_sdi_s;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_timeout;
    logic [SPI_BYTE_W-1:0] w_byte;

    logic                  r_sclk_prev;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_shift;
    logic [SPI_BYTE_W-1:0] r_write_data;
    logic [SPI_BYTE_W-1:0] r_addr;
    logic                  r_msg_flag;
    logic                  r_frame_end;
    pico_state_t           r_state;

    bit_synchronizer #(.depth(SYNC_STAGES)) u_sync_sclk (
        .i_clk (iclk),
        .i_rst (rst),
        .i_d   (sclk),
        .o_q   (w_sclk_s)
    );

    bit_synchronizer #(.depth(SYNC_STAGES)) u_sync_sdi (
        .i_clk (iclk),
        .i_rst (rst),
        .i_d   (serial_in),
        .o_q   (w_sdi_s)
    );

    assign w_rise    = w_sclk_s & ~r_sclk_prev;
    assign w_fall    = ~w_sclk_s & r_sclk_prev;
    assign w_byte    = {r_shift[SPI_BYTE_W-2:0], w_sdi_s};
    assign w_timeout = (r_idle_cnt == IDLE_MAX) && (r_state != ST_IDLE);

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            r_sclk_prev <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            if (w_rise || w_fall) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    // Timeout takes priority over a coincident rising edge.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_write_data <= '0;
            r_addr       <= '0;
            r_msg_flag   <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            r_msg_flag  <= 1'b0;
            r_frame_end <= 1'b0;
            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_end <= 1'b1;
                r_bit_cnt   <= '0;
                r_shift     <= '0;
                r_addr      <= '0;
            end else begin
`ifdef PICO_ADDR_AUTOINC_EN
                if (r_msg_flag) begin
                    r_addr <= r_addr + 1'b1;
                end
`endif
                if (w_rise) begin
                    r_shift   <= w_byte;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    case (r_state)
                        ST_IDLE: r_state <= ST_ADDR;
                        ST_ADDR: begin
                            if (r_bit_cnt == 3'd7) begin
                                r_addr  <= w_byte;
                                r_state <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (r_bit_cnt == 3'd7) begin
                                r_write_data <= w_byte;
                                r_msg_flag   <= 1'b1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign msg_flag           = r_msg_flag;
    assign write_data         = r_write_data;
    assign mux_control_signal = r_addr;
    assign frame_end          = r_frame_end;
    assign frame_active       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pico_oversampler.sv
// Scoreboard bench for pico_oversampler: directed SPI frames, monitor checks flags against queued expectations.
module tb_pico_oversampler;

    localparam int SYNC     = 2;
    localparam int IDLE_TO  = 16;
    localparam int HALF     = 4;
`ifdef PICO_ADDR_AUTOINC_EN
    localparam bit AUTOINC  = 1'b1;
`else
    localparam bit AUTOINC  = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
        logic [7:0] n;
    } exp_t;

    logic       iclk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       serial_in;
    logic       msg_flag;
    logic [7:0] write_data;
    logic [7:0] mux_control_signal;
    logic       frame_active;
    logic       frame_end;

    int errors = 0;
    int checks = 0;

    exp_t       msg_q [$];
    logic [7:0] fe_q  [$];
    logic [7:0] last_data;

    pico_oversampler #(.IDLE_TIMEOUT(IDLE_TO), .SYNC_STAGES(SYNC)) dut (
        .iclk               (iclk),
        .rst                (rst),
        .sclk               (sclk),
        .serial_in          (serial_in),
        .msg_flag           (msg_flag),
        .write_data         (write_data),
        .mux_control_signal (mux_control_signal),
        .frame_active       (frame_active),
        .frame_end          (frame_end)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT flags an output.
    initial begin
        bit         pend = 1'b0;
        logic [7:0] pend_addr = 8'h00;
        exp_t       e;
        logic [7:0] fd;
        forever begin
            @(negedge iclk);
            if (pend) begin
                check("addr_after_flag", mux_control_signal, pend_addr);
                pend = 1'b0;
            end
            if (!rst && msg_flag) begin
                if (msg_q.size() == 0) begin
                    check("unexpected_msg_flag", 1, 0);
                end else begin
                    e = msg_q.pop_front();
                    check("write_data", write_data, e.d);
                    check("addr_at_flag", mux_control_signal, e.a);
                    pend      = 1'b1;
                    pend_addr = e.n;
                end
            end
            if (!rst && frame_end) begin
                if (fe_q.size() == 0) begin
                    check("unexpected_frame_end", 1, 0);
                end else begin
                    fd = fe_q.pop_front();
                    check("fe_write_data_held", write_data, fd);
                    check("fe_addr_cleared", mux_control_signal, 8'h00);
                    check("fe_frame_inactive", frame_active, 1'b0);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input bit meas);
        int lat;
        serial_in = b;
        sclk      = 1'b0;
        repeat (HALF) @(negedge iclk);
        sclk = 1'b1;
        lat  = 0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge iclk);
            if (msg_flag && lat == 0) lat = i;
        end
        if (meas) check("flag_latency", lat, SYNC + 1);
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits, input bit meas);
        for (int i = 0; i < nbits; i++) begin
            send_bit(v[7-i], meas && (i == 7));
        end
    endtask

    task automatic end_frame(input bit timed);
        int cnt = 0;
        fe_q.push_back(last_data);
        sclk = 1'b0;
        while (cnt < 60) begin
            @(negedge iclk);
            cnt++;
            if (frame_end) break;
        end
        if (timed) check("frame_end_delay", cnt, SYNC + IDLE_TO + 2);
        else       check("frame_end_seen", frame_end, 1'b1);
        repeat (4) @(negedge iclk);
    endtask

    task automatic frame(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input int n, input bit meas);
        logic [7:0] dl [3];
        logic [7:0] a;
        exp_t       e;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        send_byte(addr, 8, 1'b0);
        check("active_after_addr", frame_active, 1'b1);
        a = addr;
        for (int i = 0; i < n; i++) begin
            e.d = dl[i];
            e.a = a;
            e.n = AUTOINC ? a + 8'd1 : a;
            msg_q.push_back(e);
            last_data = dl[i];
            send_byte(dl[i], 8, meas && (i == 0));
            a = e.n;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        sclk      = 1'b0;
        serial_in = 1'b0;
        last_data = 8'h00;
        repeat (3) @(negedge iclk);
        check("rst_msg_flag", msg_flag, 1'b0);
        check("rst_frame_end", frame_end, 1'b0);
        check("rst_frame_active", frame_active, 1'b0);
        check("rst_write_data", write_data, 8'h00);
        check("rst_addr", mux_control_signal, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge iclk);

        frame(8'h03, 8'hA5, 8'h00, 8'h00, 1, 1'b1);
        end_frame(1'b1);

        frame(8'h3D, 8'h11, 8'h22, 8'h33, 3, 1'b0);
        end_frame(1'b0);

        frame(8'hFF, 8'h01, 8'h02, 8'h00, 2, 1'b0);
        end_frame(1'b0);

        // Partial data byte: discarded, write_data keeps 0x02.
        send_byte(8'h01, 8, 1'b0);
        send_byte(8'hFF, 5, 1'b0);
        end_frame(1'b0);
        check("partial_write_data", write_data, 8'h02);

        // Reset after 12 bits aborts the frame silently.
        send_byte(8'h55, 8, 1'b0);
        send_byte(8'hA0, 4, 1'b0);
        check("mid_frame_addr", mux_control_signal, 8'h55);
        @(negedge iclk);
        rst  = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge iclk);
        check("midrst_msg_flag", msg_flag, 1'b0);
        check("midrst_frame_end", frame_end, 1'b0);
        check("midrst_frame_active", frame_active, 1'b0);
        check("midrst_write_data", write_data, 8'h00);
        check("midrst_addr", mux_control_signal, 8'h00);
        last_data = 8'h00;
        rst = 1'b0;
        repeat (5) @(negedge iclk);

        frame(8'h02, 8'h03, 8'h00, 8'h00, 1, 1'b0);
        end_frame(1'b0);

        frame(8'h40, 8'hAA, 8'hBB, 8'h00, 2, 1'b0);
        end_frame(1'b0);

        repeat (30) @(negedge iclk);
        check("msg_queue_drained", msg_q.size(), 0);
        check("fe_queue_drained", fe_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
